dvi_video_timing_gen: RTL and testbench
=======================================

Name: dvi_video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the DVI output streamer.
- Produces registered hsync/vsync/data-enable and the pixel X/Y coordinates that the pixel source and the streamer consume.
- Fully parameterised raster; defaults to 640x480@60 (25.175 MHz pixel clock).
- Advances one pixel per enabled cycle, so an upstream stall can freeze the raster without glitching syncs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)

Ports:
iClk_0  in  1  pixel clock
iRst_n  in  1  asynchronous, active-low reset
iEn  in  1  pixel advance enable; raster frozen when 0
oHsync  out  1  horizontal sync, polarity HS_POL
oVsync  out  1  vertical sync, polarity VS_POL
oDe  out  1  active-video data enable
oX  out  12  pixel column; valid when oDe=1, else 0
oY  out  12  pixel row; valid when oDe=1, else 0
oLineStart  out  1  one-cycle pulse with the first active pixel of each line
oFrameStart  out  1  one-cycle pulse with pixel (0,0) of each frame
oRgb  out  24  colour-bar pixel {R,G,B}; see Optional Feature

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters: hCnt in 0..H_TOTAL-1 and vCnt in 0..V_TOTAL-1, both 12 bits.
  - Both advance only when iEn=1.
  - hCnt wraps H_TOTAL-1 -> 0. vCnt increments only on that wrap and wraps V_TOTAL-1 -> 0 on the same edge.
- Regions, decoded combinationally from hCnt/vCnt:
  - Active when hCnt<H_ACTIVE and vCnt<V_ACTIVE.
  - Hsync asserted for H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC.
  - Vsync asserted for V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC. Vsync changes only at the hCnt wrap (line-aligned).
- Outputs are registered, so they show the state of the counters one cycle earlier (latency 1). Outputs update only when iEn=1 and hold otherwise.
- oX/oY are hCnt/vCnt when active, forced to 0 when blanking.
- oLineStart = active && hCnt==0. oFrameStart = active && hCnt==0 && vCnt==0. Each pulses for exactly one enabled cycle.
- Reset (async assert, sync release via register clock):
  - hCnt=vCnt=0.
  - oDe=0, oX=oY=0, oLineStart=oFrameStart=0, oRgb=0.
  - oHsync=~HS_POL, oVsync=~VS_POL (inactive level).
  - First enabled edge after release presents pixel (0,0) with oFrameStart=1.
- Reset mid-frame: all outputs go to reset values immediately (no clock needed). The raster restarts at (0,0).
- iEn low for N cycles: every output holds its value and no pulse is duplicated or lost.
- Parameter legality (elaboration check, $error): every field >=1; H_TOTAL and V_TOTAL < 4096.

Optional Feature:
- Macro: DVI_TIMING_GEN_COLOR_BARS_EN.
- Defined: oRgb carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide. The last bar absorbs the remainder.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar components are 8'hFF or 8'h00.
  - Registered with the same latency as oDe, and 0 when oDe=0.
  - The bar index is computed with a compare chain, not a divider.
- Undefined: oRgb is tied to 24'h0. The port remains so the interface is identical in both builds.

Decomposition:
- Shared package dvi_video_pkg:
  - default 640x480 timing constants
  - colour-bar RGB constants
  - 12-bit coordinate width constant
- One sub-module: dvi_raster_counter. It holds the parameterised wrap counter with enable and carry-out and is instantiated for both H and V. Region decode and output registers stay in the top module.

Test Plan:
- Reset with iEn=1, release -> first edge: oDe=1, oX=0, oY=0, oFrameStart=1, oLineStart=1; oHsync=1, oVsync=1 (active-low, idle).
- Run one full line -> oDe high exactly 640 cycles; oHsync low exactly 96 cycles starting 656 cycles after line start; period 800 cycles.
- Run one full frame -> 480 oLineStart pulses; oVsync low for 2x800=1600 cycles starting at line 490; oFrameStart period 420000 cycles.
- Toggle iEn 50% random during line 3 -> oX sequence 0..639 has no gaps or repeats; exactly one oLineStart for line 3.
- Assert iRst_n low at (x=300, y=200) between clock edges -> outputs at reset values before the next edge; after release the raster restarts at (0,0).
- With DVI_TIMING_GEN_COLOR_BARS_EN: oX=0 -> oRgb=24'hFFFFFF; oX=80 -> 24'hFFFF00; oX=639 -> 24'h000000; blanking -> 24'h0. Without the macro, oRgb stays 0 throughout.

Source files
------------

// File: rtl/dvi_video_pkg.sv
// Shared constants for the DVI raster timing generator: default 640x480@60 timing,
// coordinate width and the colour-bar palette.
package dvi_video_pkg;

    localparam int unsigned CoordW = 12;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    localparam logic [23:0] RgbWhite   = 24'hFFFFFF;
    localparam logic [23:0] RgbYellow  = 24'hFFFF00;
    localparam logic [23:0] RgbCyan    = 24'h00FFFF;
    localparam logic [23:0] RgbGreen   = 24'h00FF00;
    localparam logic [23:0] RgbMagenta = 24'hFF00FF;
    localparam logic [23:0] RgbRed     = 24'hFF0000;
    localparam logic [23:0] RgbBlue    = 24'h0000FF;
    localparam logic [23:0] RgbBlack   = 24'h000000;

    // Bar index 0 is the leftmost bar.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        unique case (idx)
            3'd0:    rgb = RgbWhite;
            3'd1:    rgb = RgbYellow;
            3'd2:    rgb = RgbCyan;
            3'd3:    rgb = RgbGreen;
            3'd4:    rgb = RgbMagenta;
            3'd5:    rgb = RgbRed;
            3'd6:    rgb = RgbBlue;
            default: rgb = RgbBlack;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/dvi_raster_counter.sv
// Wrap-around counter 0..Total-1 with enable and a carry-out that is high on the
// enabled cycle in which the counter wraps.
module dvi_raster_counter
    import dvi_video_pkg::*;
#(
    parameter int unsigned Total = 800
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [CoordW-1:0] cnt_o,
    output logic              wrap_o
);

    localparam logic [CoordW-1:0] Last = CoordW'(Total - 1);

    logic [CoordW-1:0] cnt_q, cnt_d;
    logic              at_last;

    assign at_last = (cnt_q == Last);
    assign wrap_o  = en_i && at_last;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + CoordW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dvi_video_timing_gen.sv
// Registered DVI raster timing generator (syncs, DE, X/Y, line/frame pulses).
// Define DVI_TIMING_GEN_COLOR_BARS_EN to drive 8 colour bars on oRgb; otherwise oRgb is 0.
module dvi_video_timing_gen
    import dvi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic              iClk_0,
    input  logic              iRst_n,
    input  logic              iEn,
    output logic              oHsync,
    output logic              oVsync,
    output logic              oDe,
    output logic [CoordW-1:0] oX,
    output logic [CoordW-1:0] oY,
    output logic              oLineStart,
    output logic              oFrameStart,
    output logic [23:0]       oRgb
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CoordW-1:0] HActEnd  = CoordW'(H_ACTIVE);
    localparam logic [CoordW-1:0] HSyncBeg = CoordW'(H_ACTIVE + H_FP);
    localparam logic [CoordW-1:0] HSyncEnd = CoordW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CoordW-1:0] VActEnd  = CoordW'(V_ACTIVE);
    localparam logic [CoordW-1:0] VSyncBeg = CoordW'(V_ACTIVE + V_FP);
    localparam logic [CoordW-1:0] VSyncEnd = CoordW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        HTotal >= 4096 || VTotal >= 4096) begin : g_param_check
        $error("dvi_video_timing_gen: illegal raster parameters");
    end

    logic [CoordW-1:0] h_cnt, v_cnt;
    logic              h_wrap, v_wrap;

    dvi_raster_counter #(
        .Total (HTotal)
    ) u_h_cnt (
        .clk_i  (iClk_0),
        .rst_ni (iRst_n),
        .en_i   (iEn),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    // V advances only on the H wrap, so vsync is inherently line-aligned.
    dvi_raster_counter #(
        .Total (VTotal)
    ) u_v_cnt (
        .clk_i  (iClk_0),
        .rst_ni (iRst_n),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    // A frame can only end on the last pixel of a line.
    assert property (@(posedge iClk_0) disable iff (!iRst_n) v_wrap |-> h_wrap);

    logic              active;
    logic              de_q, de_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic [CoordW-1:0] x_q, x_d, y_q, y_d;
    logic              ls_q, ls_d;
    logic              fs_q, fs_d;

    always_comb begin
        active  = (h_cnt < HActEnd) && (v_cnt < VActEnd);
        de_d    = active;
        hsync_d = ((h_cnt >= HSyncBeg) && (h_cnt < HSyncEnd)) ? HS_POL : ~HS_POL;
        vsync_d = ((v_cnt >= VSyncBeg) && (v_cnt < VSyncEnd)) ? VS_POL : ~VS_POL;
        x_d     = active ? h_cnt : '0;
        y_d     = active ? v_cnt : '0;
        ls_d    = active && (h_cnt == '0);
        fs_d    = ls_d && (v_cnt == '0);
    end

    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (iEn) begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign oDe         = de_q;
    assign oHsync      = hsync_q;
    assign oVsync      = vsync_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oLineStart  = ls_q;
    assign oFrameStart = fs_q;

`ifdef DVI_TIMING_GEN_COLOR_BARS_EN
    localparam logic [CoordW-1:0] BarW = CoordW'(H_ACTIVE / 8);

    logic [2:0]  bar_idx;
    logic [23:0] rgb_q, rgb_d;

    // Smallest bar whose right edge lies beyond h_cnt; anything past bar 6 is the last bar.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (h_cnt < BarW * CoordW'(i + 1)) begin
                bar_idx = 3'(i);
            end
        end
        rgb_d = active ? bar_rgb(bar_idx) : '0;
    end

    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            rgb_q <= '0;
        end else if (iEn) begin
            rgb_q <= rgb_d;
        end
    end

    assign oRgb = rgb_q;
`else
    assign oRgb = '0;
`endif

endmodule

// File: tb/tb_dvi_video_timing_gen.sv
// Randomised-enable bench for dvi_video_timing_gen on a small raster, checked every cycle
// against a pixel-index reference model.
module tb_dvi_video_timing_gen;

    localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 2;
    localparam int unsigned VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        hsync, vsync, de, ls, fs;
    logic [11:0] x, y;
    logic [23:0] rgb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_en = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    dvi_video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) dut (
        .iClk_0      (clk),
        .iRst_n      (rst_n),
        .iEn         (en),
        .oHsync      (hsync),
        .oVsync      (vsync),
        .oDe         (de),
        .oX          (x),
        .oY          (y),
        .oLineStart  (ls),
        .oFrameStart (fs),
        .oRgb        (rgb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after n_en enabled edges since reset: pixel index n_en-1.
    task automatic check_model();
        int unsigned p, h, v, bar;
        logic e_de, e_hs, e_vs, e_ls, e_fs;
        logic [11:0] e_x, e_y;
        logic [23:0] e_rgb;
        if (n_en == 0) begin
            e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0; e_x = 0; e_y = 0; e_rgb = 0;
        end else begin
            p    = n_en - 1;
            h    = p % HT;
            v    = (p / HT) % VT;
            e_de = (h < HA) && (v < VA);
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            e_x  = e_de ? 12'(h) : 12'd0;
            e_y  = e_de ? 12'(v) : 12'd0;
            e_ls = e_de && (h == 0);
            e_fs = e_ls && (v == 0);
            e_rgb = 24'h0;
`ifdef DVI_TIMING_GEN_COLOR_BARS_EN
            bar = h / (HA / 8);
            if (bar > 7) bar = 7;
            if (e_de) e_rgb = bar_tab[bar];
`endif
        end
        check_eq("de", 32'(de), 32'(e_de));
        check_eq("hsync", 32'(hsync), 32'(e_hs));
        check_eq("vsync", 32'(vsync), 32'(e_vs));
        check_eq("x", 32'(x), 32'(e_x));
        check_eq("y", 32'(y), 32'(e_y));
        check_eq("line_start", 32'(ls), 32'(e_ls));
        check_eq("frame_start", 32'(fs), 32'(e_fs));
        check_eq("rgb", 32'(rgb), 32'(e_rgb));
    endtask

    // Drive enable at the falling edge, clock once, then compare at the next falling edge.
    task automatic step(input logic en_val);
        en = en_val;
        @(posedge clk);
        if (en && rst_n) n_en++;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int unsigned c_ls, c_fs, c_de, c_hs, c_vs;

        en = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_de", 32'(de), 32'd0);
        check_eq("rst_hsync", 32'(hsync), 32'd1);
        check_eq("rst_vsync", 32'(vsync), 32'd1);
        check_eq("rst_rgb", 32'(rgb), 32'd0);
        rst_n = 1'b1;

        // First enabled edge presents pixel (0,0).
        step(1'b1);
        check_eq("first_de", 32'(de), 32'd1);
        check_eq("first_fs", 32'(fs), 32'd1);
        check_eq("first_ls", 32'(ls), 32'd1);
        check_eq("first_xy", 32'({x, y}), 32'd0);
`ifdef DVI_TIMING_GEN_COLOR_BARS_EN
        check_eq("first_rgb", 32'(rgb), 32'hFFFFFF);
`endif

        // One full frame with enable held high; pulse and sync-width tallies.
        c_ls = 32'(ls); c_fs = 32'(fs); c_de = 32'(de); c_hs = 0; c_vs = 0;
        for (int i = 1; i < HT * VT; i++) begin
            step(1'b1);
            c_ls += 32'(ls); c_fs += 32'(fs); c_de += 32'(de);
            c_hs += 32'(!hsync); c_vs += 32'(!vsync);
        end
        check_eq("frame_ls_count", c_ls, VA);
        check_eq("frame_fs_count", c_fs, 1);
        check_eq("frame_de_count", c_de, HA * VA);
        check_eq("frame_hs_low", c_hs, HS * VT);
        check_eq("frame_vs_low", c_vs, VS * HT);
        step(1'b1);
        check_eq("wrap_fs", 32'(fs), 32'd1);

        // Random 50% enable for several frames: holds and pulses checked every cycle.
        for (int i = 0; i < 4 * HT * VT; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        // Mid-frame reset at pixel (10,3), asserted between edges.
        while (((n_en - 1) % (HT * VT)) != 3 * HT + 10) step(1'b1);
        check_eq("pre_rst_x", 32'(x), 32'd10);
        check_eq("pre_rst_y", 32'(y), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_de", 32'(de), 32'd0);
        check_eq("async_rst_x", 32'(x), 32'd0);
        check_eq("async_rst_hsync", 32'(hsync), 32'd1);
        check_eq("async_rst_ls", 32'(ls), 32'd0);
        n_en = 0;
        @(negedge clk);
        check_model();
        rst_n = 1'b1;
        step(1'b1);
        check_eq("restart_fs", 32'(fs), 32'd1);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
